// File: rtl/pipelined_reduce_gate_pkg.sv
// Shared definitions for the pipelined reduction gate: mode encodings,
// legal parameter ranges and the tree-shape helpers used at elaboration.
package pipelined_reduce_gate_pkg;

    localparam logic [1:0] MODE_AND = 2'b00;
    localparam logic [1:0] MODE_OR  = 2'b01;
    localparam logic [1:0] MODE_XOR = 2'b10;
    localparam int         MODE_INV = 2;

    localparam int NUM_INPUTS_MIN = 2;
    localparam int NUM_INPUTS_MAX = 64;
    localparam int WIDTH_MIN      = 1;
    localparam int WIDTH_MAX      = 32;
    localparam int STAGES_MIN     = 1;
    localparam int STAGES_MAX     = 4;

    // ceil(log2(n)): number of pairwise combine levels needed for n operands
    function automatic int tree_depth(input int n);
        int d;
        int span;
        d = 0;
        span = 1;
        while (span < n) begin
            span = span * 2;
            d = d + 1;
        end
        return d;
    endfunction

    // Operands left after a number of levels; odd leftovers pass through
    function automatic int count_after(input int n, input int levels);
        int c;
        c = n;
        for (int i = 0; i < levels; i++) begin
            c = (c + 1) / 2;
        end
        return c;
    endfunction

    // Combine levels completed before stage k when levels are dealt out evenly
    function automatic int levels_before(input int depth, input int stages, input int k);
        int per;
        per = (depth + stages - 1) / stages;
        return (k * per < depth) ? k * per : depth;
    endfunction

endpackage

// File: rtl/pipelined_reduce_gate_reduce_stage.sv
// One pipeline slot: combines LEVELS tree levels of its partial operands and
// registers them with the transaction's mode behind a valid/ready handshake.
module pipelined_reduce_gate_reduce_stage
    import pipelined_reduce_gate_pkg::*;
#(
    parameter int TOTAL   = 6,
    parameter int WIDTH   = 1,
    parameter int N_IN    = 6,
    parameter int LEVELS  = 1,
    parameter bit IS_LAST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     up_valid,
    output logic                     up_ready,
    input  logic [2:0]               up_mode,
    input  logic [TOTAL*WIDTH-1:0]   up_data,
    output logic                     dn_valid,
    input  logic                     dn_ready,
    output logic [2:0]               dn_mode,
    output logic [TOTAL*WIDTH-1:0]   dn_data
);

    localparam int N_OUT = count_after(N_IN, LEVELS);

    logic [WIDTH-1:0]       node [TOTAL];
    logic [TOTAL*WIDTH-1:0] data_nxt;
    logic                   vld_p0;
    logic [2:0]             mode_p0;
    logic [TOTAL*WIDTH-1:0] data_p0;

    function automatic logic [WIDTH-1:0] combine(input logic [1:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        case (op)
            MODE_AND: return a & b;
            MODE_OR:  return a | b;
            default:  return a ^ b;
        endcase
    endfunction

    // Pairs reduce in place (write index never overtakes read index); an
    // unpaired last node moves down unchanged so no identity padding is needed.
    always_comb begin
        int n;
        n = N_IN;
        for (int i = 0; i < TOTAL; i++) begin
            node[i] = up_data[i*WIDTH +: WIDTH];
        end
        for (int l = 0; l < LEVELS; l++) begin
            for (int j = 0; j < TOTAL / 2; j++) begin
                if (j < n / 2) begin
                    node[j] = combine(up_mode[1:0], node[2*j], node[2*j+1]);
                end
            end
            if (n % 2 == 1) begin
                node[n/2] = node[n-1];
            end
            n = (n + 1) / 2;
        end
        data_nxt = '0;
        for (int i = 0; i < N_OUT; i++) begin
            data_nxt[i*WIDTH +: WIDTH] = node[i];
        end
        if (IS_LAST) begin
            data_nxt[WIDTH-1:0] = (up_mode[1:0] == 2'b11) ? '0
                                : node[0] ^ {WIDTH{up_mode[MODE_INV]}};
        end
    end

    // An empty slot always accepts, so bubbles collapse under a stalled output
    assign up_ready = !vld_p0 || dn_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0  <= 1'b0;
            mode_p0 <= '0;
            data_p0 <= '0;
        end else if (up_ready) begin
            vld_p0 <= up_valid;
            if (up_valid) begin
                mode_p0 <= up_mode;
                data_p0 <= data_nxt;
            end
        end
    end

    assign dn_valid = vld_p0;
    assign dn_mode  = mode_p0;
    assign dn_data  = data_p0;

endmodule

// File: rtl/pipelined_reduce_gate.sv
// Parametrised NUM_INPUTS x WIDTH bitwise AND/OR/XOR reduction with input
// bubbles and optional output inversion, spread over STAGES registered slots.
module pipelined_reduce_gate
    import pipelined_reduce_gate_pkg::*;
#(
    parameter int                    NUM_INPUTS  = 6,
    parameter int                    WIDTH       = 1,
    parameter logic [NUM_INPUTS-1:0] BubblesMask = '0,
    parameter int                    STAGES      = 1
) (
    input  logic                        Clock,
    input  logic                        Reset,
    input  logic [NUM_INPUTS*WIDTH-1:0] Inputs,
    input  logic [2:0]                  Mode,
    input  logic                        InValid,
    output logic                        InReady,
    output logic [WIDTH-1:0]            Result,
    output logic                        OutValid,
    input  logic                        OutReady
);

    localparam int BUS_W = NUM_INPUTS * WIDTH;
    localparam int DEPTH = tree_depth(NUM_INPUTS);

    if (NUM_INPUTS < NUM_INPUTS_MIN || NUM_INPUTS > NUM_INPUTS_MAX) begin : g_bad_num_inputs
        $error("pipelined_reduce_gate: NUM_INPUTS out of range");
    end
    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("pipelined_reduce_gate: WIDTH out of range");
    end
    if (STAGES < STAGES_MIN || STAGES > STAGES_MAX || STAGES > DEPTH + 1) begin : g_bad_stages
        $error("pipelined_reduce_gate: STAGES out of range");
    end

    // Index 0 is the block input; index k+1 is the output of stage k
    logic [STAGES:0]            vld_bus;
    logic [STAGES:0]            rdy_bus;
    logic [STAGES:0][2:0]       mode_bus;
    logic [STAGES:0][BUS_W-1:0] data_bus;
    logic                       unused_tail;

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_bubble
        assign data_bus[0][i*WIDTH +: WIDTH] = Inputs[i*WIDTH +: WIDTH] ^ {WIDTH{BubblesMask[i]}};
    end

    assign vld_bus[0]       = InValid;
    assign mode_bus[0]      = Mode;
    assign rdy_bus[STAGES]  = OutReady;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LV_LO = levels_before(DEPTH, STAGES, k);
        localparam int LV_HI = levels_before(DEPTH, STAGES, k + 1);

        pipelined_reduce_gate_reduce_stage #(
            .TOTAL   (NUM_INPUTS),
            .WIDTH   (WIDTH),
            .N_IN    (count_after(NUM_INPUTS, LV_LO)),
            .LEVELS  (LV_HI - LV_LO),
            .IS_LAST (k == STAGES - 1)
        ) u_stage (
            .clk      (Clock),
            .rst      (Reset),
            .up_valid (vld_bus[k]),
            .up_ready (rdy_bus[k]),
            .up_mode  (mode_bus[k]),
            .up_data  (data_bus[k]),
            .dn_valid (vld_bus[k+1]),
            .dn_ready (rdy_bus[k+1]),
            .dn_mode  (mode_bus[k+1]),
            .dn_data  (data_bus[k+1])
        );
    end

    assign InReady  = !Reset && rdy_bus[0];
    assign OutValid = vld_bus[STAGES];
    assign Result   = data_bus[STAGES][WIDTH-1:0];

    // Final mode and the upper (always zero) slots of the last stage are not needed
    assign unused_tail = ^{mode_bus[STAGES], data_bus[STAGES][BUS_W-1:WIDTH]};

endmodule

// File: tb/tb_pipelined_reduce_gate.sv
// Scoreboard bench: four parameterisations share one stimulus bus; the driver
// queues expected results on accept and a monitor checks them on output.
module tb_pipelined_reduce_gate;

    typedef struct {
        int         dut;
        logic [3:0] res;
        int         acc;
        bit         ex;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] in_bus;
    logic [2:0]  mode;
    logic        in_valid;
    logic        out_ready;
    int          sel;
    int          cyc;
    int          n_tests;
    int          n_fail;
    exp_t        sb[$];

    logic       ir0, ir1, ir2, ir3;
    logic       ov0, ov1, ov2, ov3;
    logic       r0, r2;
    logic [3:0] r1;
    logic [1:0] r3;

    logic       cur_valid;
    logic       cur_rdy;
    logic [3:0] cur_res;
    logic       prev_stall;
    logic [3:0] prev_res;

    pipelined_reduce_gate dut0 (
        .Clock(clk), .Reset(rst), .Inputs(in_bus[5:0]), .Mode(mode),
        .InValid(in_valid && sel == 0), .InReady(ir0), .Result(r0),
        .OutValid(ov0), .OutReady(out_ready)
    );

    pipelined_reduce_gate #(.NUM_INPUTS(8), .WIDTH(4), .BubblesMask(8'h01), .STAGES(1)) dut1 (
        .Clock(clk), .Reset(rst), .Inputs(in_bus), .Mode(mode),
        .InValid(in_valid && sel == 1), .InReady(ir1), .Result(r1),
        .OutValid(ov1), .OutReady(out_ready)
    );

    pipelined_reduce_gate #(.NUM_INPUTS(6), .WIDTH(1), .BubblesMask(6'h00), .STAGES(3)) dut2 (
        .Clock(clk), .Reset(rst), .Inputs(in_bus[5:0]), .Mode(mode),
        .InValid(in_valid && sel == 2), .InReady(ir2), .Result(r2),
        .OutValid(ov2), .OutReady(out_ready)
    );

    pipelined_reduce_gate #(.NUM_INPUTS(5), .WIDTH(2), .BubblesMask(5'h00), .STAGES(2)) dut3 (
        .Clock(clk), .Reset(rst), .Inputs(in_bus[9:0]), .Mode(mode),
        .InValid(in_valid && sel == 3), .InReady(ir3), .Result(r3),
        .OutValid(ov3), .OutReady(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        cur_valid = 1'b0;
        cur_rdy   = 1'b0;
        cur_res   = 4'h0;
        case (sel)
            0: begin cur_valid = ov0; cur_rdy = ir0; cur_res = {3'b000, r0}; end
            1: begin cur_valid = ov1; cur_rdy = ir1; cur_res = r1; end
            2: begin cur_valid = ov2; cur_rdy = ir2; cur_res = {3'b000, r2}; end
            default: begin cur_valid = ov3; cur_rdy = ir3; cur_res = {2'b00, r3}; end
        endcase
    end

    function automatic int stages_of(input int d);
        case (d)
            2:       return 3;
            3:       return 2;
            default: return 1;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops one expectation per output transfer; also checks hold under stall
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_hold", {27'b0, cur_valid, cur_res}, {27'b0, 1'b1, prev_res});
            end
            if (cur_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_output", {28'b0, cur_res}, 32'hDEAD);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("result_dut%0d", e.dut), {28'b0, cur_res}, {28'b0, e.res});
                    if (e.ex) begin
                        check($sformatf("latency_dut%0d", e.dut), cyc - e.acc, stages_of(e.dut));
                    end
                end
            end
            prev_stall <= cur_valid && !out_ready;
            prev_res   <= cur_res;
        end
    end

    task automatic send(input int d, input logic [31:0] v, input logic [2:0] m,
                        input logic [3:0] res, input bit ex);
        bit r;
        int t;
        sel      = d;
        in_bus   = v;
        mode     = m;
        in_valid = 1'b1;
        r = 1'b0;
        t = 0;
        while (!r && t < 50) begin
            @(negedge clk);
            r = cur_rdy;
            @(posedge clk);
            t++;
        end
        if (r) sb.push_back('{d, res, cyc, ex});
        else   check("accept_timeout", 32'(r), 32'd1);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("drain_empty", sb.size(), 0);
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        cyc        = 0;
        rst        = 1'b1;
        in_bus     = '0;
        mode       = 3'b000;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        sel        = 0;
        prev_stall = 1'b0;
        prev_res   = '0;

        #12;
        check("reset_outvalid", {ov3, ov2, ov1, ov0}, 4'h0);
        check("reset_inready", {ir3, ir2, ir1, ir0}, 4'h0);
        check("reset_result", {r3, r2, r1, r0}, 8'h00);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("inready_after_reset", {ir3, ir2, ir1, ir0}, 4'hF);
        @(posedge clk); #1;

        // Defaults 6x1, STAGES 1
        send(0, 32'h3F, 3'b000, 4'h1, 1'b1);
        send(0, 32'h3E, 3'b000, 4'h0, 1'b1);
        send(0, 32'h07, 3'b010, 4'h1, 1'b1);
        send(0, 32'h00, 3'b101, 4'h1, 1'b1);
        send(0, 32'h3F, 3'b111, 4'h0, 1'b1);
        drain();

        // 8x4, operand 0 bubbled
        send(1, 32'h0000_0000, 3'b010, 4'hF, 1'b1);
        send(1, 32'h0000_0000, 3'b110, 4'h0, 1'b1);
        send(1, 32'hFFFF_FFF0, 3'b000, 4'hF, 1'b1);
        send(1, 32'h0000_000F, 3'b001, 4'h0, 1'b1);
        send(1, 32'h0000_0A0F, 3'b001, 4'hA, 1'b1);
        drain();

        // 5x2, STAGES 2: operand 4 reaches the root through pass-through nodes
        send(3, 32'h200, 3'b001, 4'h2, 1'b1);
        send(3, 32'h3FF, 3'b000, 4'h3, 1'b1);
        send(3, 32'h201, 3'b010, 4'h3, 1'b1);
        send(3, 32'h1FF, 3'b100, 4'h2, 1'b1);
        drain();

        // STAGES 3, back-to-back with per-transaction modes
        send(2, 32'h3F, 3'b000, 4'h1, 1'b1);
        send(2, 32'h04, 3'b001, 4'h1, 1'b1);
        send(2, 32'h3F, 3'b100, 4'h0, 1'b1);
        send(2, 32'h3F, 3'b011, 4'h0, 1'b1);
        drain();

        // STAGES 3, output stalled: three accepts fill the pipe, then InReady drops
        out_ready = 1'b0;
        send(2, 32'h3F, 3'b000, 4'h1, 1'b0);
        send(2, 32'h3E, 3'b000, 4'h0, 1'b0);
        send(2, 32'h01, 3'b010, 4'h1, 1'b0);
        in_bus   = 32'h03;
        mode     = 3'b010;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_inready", {31'b0, cur_rdy}, 32'd0);
            @(posedge clk);
        end
        #1;
        check("full_queue_depth", sb.size(), 3);
        out_ready = 1'b1;
        send(2, 32'h03, 3'b010, 4'h0, 1'b0);
        drain();

        // Asynchronous reset with two transactions in flight
        out_ready = 1'b0;
        send(2, 32'h3F, 3'b000, 4'h1, 1'b0);
        send(2, 32'h00, 3'b001, 4'h0, 1'b0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        check("inflight_outvalid", {31'b0, cur_valid}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("async_reset_outvalid", {31'b0, cur_valid}, 32'd0);
        check("async_reset_inready", {31'b0, cur_rdy}, 32'd0);
        check("async_reset_result", {28'b0, cur_res}, 32'd0);
        sb.delete();
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        check("post_reset_inready", {31'b0, cur_rdy}, 32'd1);
        send(2, 32'h00, 3'b101, 4'h1, 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
